// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, functs, ALU encodings and sequencer states
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_COMMIT = 3'd6;
    localparam logic [2:0] ST_HALT   = 3'd7;

    // Instruction class decides the phase path after EXEC.
    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J
    } insn_cls_e;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem2reg;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{reg_dst: 1'b0, alu_src: 1'b1, mem2reg: 1'b0, alu_op: ALU_ADD};

    function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] jt);
        return {pc[31:28], jt, 2'b00};
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] pcp4, input logic [31:0] imm);
        return pcp4 + {imm[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational instruction-register to control decode
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [31:0] ir_i,
    output ctrl_t       ctrl_o,
    output insn_cls_e   cls_o,
    output logic        illegal_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = ir_i[31:26];
    assign funct  = ir_i[5:0];
    // Register and immediate fields are consumed by the datapath, not here.
    assign unused_fields = ^ir_i[25:6];

    always_comb begin
        ctrl_o    = CTRL_RESET;
        cls_o     = CLS_ALU;
        illegal_o = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_o.reg_dst = 1'b1;
                ctrl_o.alu_src = 1'b0;
                case (funct)
                    FN_ADD:  ctrl_o.alu_op = ALU_ADD;
                    FN_SUB:  ctrl_o.alu_op = ALU_SUB;
                    FN_AND:  ctrl_o.alu_op = ALU_AND;
                    FN_OR:   ctrl_o.alu_op = ALU_OR;
                    FN_SLT:  ctrl_o.alu_op = ALU_SLT;
                    default: illegal_o     = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl_o.mem2reg = 1'b1;
                cls_o          = CLS_LW;
            end
            OP_SW: begin
                cls_o = CLS_SW;
            end
            OP_ADDI: begin
                cls_o = CLS_ALU;
            end
            OP_BEQ: begin
                ctrl_o.alu_src = 1'b0;
                ctrl_o.alu_op  = ALU_SUB;
                cls_o          = CLS_BEQ;
            end
            OP_J: begin
                cls_o = CLS_J;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_ctrl_seq.sv
// rtl/mips_ctrl_seq.sv - multi-cycle control sequencer driving the yIF/yID/yEX/yDM/yWB datapath
module mips_ctrl_seq
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'd128,
    parameter int          MAX_INSNS = 43,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      ins,
    input  logic [31:0]      pcp4,
    input  logic [31:0]      imm,
    input  logic [25:0]      jtarget,
    input  logic             zero,
    output logic [31:0]      pc,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src,
    output logic             mem2reg,
    output logic             mem_read,
    output logic             mem_write,
    output logic [2:0]       alu_op,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam bit               HAS_LIMIT = (MAX_INSNS != 0);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(MAX_INSNS);

    logic [2:0]       state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;

    ctrl_t            dec_ctrl;
    insn_cls_e        dec_cls;
    logic             dec_illegal;

    mips_ctrl_decode u_decode (
        .ir_i      (ir_q),
        .ctrl_o    (dec_ctrl),
        .cls_o     (dec_cls),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = RESET_PC;
                    retired_d = '0;
                    illegal_d = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_d    = ins;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    ctrl_d  = dec_ctrl;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (dec_cls)
                    CLS_LW, CLS_SW:  state_d = ST_MEM;
                    CLS_BEQ, CLS_J:  state_d = ST_COMMIT;
                    default:         state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                state_d = (dec_cls == CLS_LW) ? ST_WB : ST_COMMIT;
            end
            ST_WB: begin
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (dec_cls == CLS_J) begin
                    pc_d = jump_target(pc_q, jtarget);
                end else if (dec_cls == CLS_BEQ && zero) begin
                    pc_d = branch_target(pcp4, imm);
                end else begin
                    pc_d = pcp4;
                end
                retired_d = retired_q + 1'b1;
                state_d   = (HAS_LIMIT && retired_d == LIMIT_CNT) ? ST_HALT : ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are registered from the next state so each lines up with its phase.
        reg_write_d = (state_d == ST_WB);
        mem_read_d  = (state_d == ST_MEM) && (dec_cls == CLS_LW);
        mem_write_d = (state_d == ST_MEM) && (dec_cls == CLS_SW);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_HALT);
        halted_d    = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            pc_q        <= RESET_PC;
            retired_q   <= '0;
            ctrl_q      <= CTRL_RESET;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            retired_q   <= retired_d;
            ctrl_q      <= ctrl_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign pc        = pc_q;
    assign reg_dst   = ctrl_q.reg_dst;
    assign alu_src   = ctrl_q.alu_src;
    assign mem2reg   = ctrl_q.mem2reg;
    assign alu_op    = ctrl_q.alu_op;
    assign reg_write = reg_write_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_mips_ctrl_seq.sv
// tb/tb_mips_ctrl_seq.sv - self-checking bench for mips_ctrl_seq
module tb_mips_ctrl_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] ins;
    logic [31:0] pcp4;
    logic [31:0] imm;
    logic [25:0] jtarget;
    logic        zero;

    logic [31:0] pc;
    logic        reg_dst, reg_write, alu_src, mem2reg, mem_read, mem_write;
    logic [2:0]  alu_op;
    logic        busy, halted, illegal;
    logic [15:0] retired;

    logic [31:0] m3_pc;
    logic        m3_busy, m3_halted, m3_illegal;
    logic [15:0] m3_retired;
    logic        m3_unused_reg_dst, m3_unused_reg_write, m3_unused_alu_src;
    logic        m3_unused_mem2reg, m3_unused_mem_read, m3_unused_mem_write;
    logic [2:0]  m3_unused_alu_op;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_pc;
    logic [15:0] m_ret;
    bit          m_halt;

    mips_ctrl_seq dut (
        .clk(clk), .rst(rst), .start(start), .ins(ins), .pcp4(pcp4), .imm(imm),
        .jtarget(jtarget), .zero(zero), .pc(pc), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src(alu_src), .mem2reg(mem2reg), .mem_read(mem_read), .mem_write(mem_write),
        .alu_op(alu_op), .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
    );

    mips_ctrl_seq #(.MAX_INSNS(3)) dut_m3 (
        .clk(clk), .rst(rst), .start(start), .ins(ins), .pcp4(pcp4), .imm(imm),
        .jtarget(jtarget), .zero(zero), .pc(m3_pc), .reg_dst(m3_unused_reg_dst),
        .reg_write(m3_unused_reg_write), .alu_src(m3_unused_alu_src),
        .mem2reg(m3_unused_mem2reg), .mem_read(m3_unused_mem_read),
        .mem_write(m3_unused_mem_write), .alu_op(m3_unused_alu_op), .busy(m3_busy),
        .halted(m3_halted), .illegal(m3_illegal), .retired(m3_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc = 32'd128; m_ret = 16'd0; m_halt = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m_pc = 32'd128; m_ret = 16'd0; m_halt = 1'b0;
        chk("start_pc", pc, 32'd128);
        chk("start_retired", retired, 0);
        chk("start_illegal", illegal, 0);
        chk("start_busy", busy, 1);
        chk("start_halted", halted, 0);
    endtask

    // Drives one instruction for its whole lifetime and compares observed phases to the ISA rules.
    task automatic run_insn(input logic [31:0] i_ins, input logic [31:0] i_pcp4, input logic i_z);
        logic [5:0]  op, fn;
        bit          is_r, is_lw, is_sw, is_addi, is_beq, is_j, legal, writes;
        int          lat, cyc, n_rw, n_mr, n_mw;
        logic [2:0]  exp_op;
        logic        m2r_rw;
        logic [31:0] exp_pc;
        logic [15:0] exp_ret;
        bit          exp_halt;
        ins = i_ins; pcp4 = i_pcp4; zero = i_z;
        imm = {{16{i_ins[15]}}, i_ins[15:0]};
        jtarget = i_ins[25:0];
        op = i_ins[31:26]; fn = i_ins[5:0];
        is_r    = (op == 6'h00) && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a});
        is_lw   = (op == 6'h23);
        is_sw   = (op == 6'h2b);
        is_addi = (op == 6'h08);
        is_beq  = (op == 6'h04);
        is_j    = (op == 6'h02);
        legal   = is_r || is_lw || is_sw || is_addi || is_beq || is_j;
        writes  = is_r || is_lw || is_addi;
        exp_op = 3'b010;
        if (is_beq) exp_op = 3'b110;
        if (is_r) begin
            case (fn)
                6'h22:   exp_op = 3'b110;
                6'h24:   exp_op = 3'b000;
                6'h25:   exp_op = 3'b001;
                6'h2a:   exp_op = 3'b111;
                default: exp_op = 3'b010;
            endcase
        end
        if (!legal) lat = 2;
        else if (is_j || is_beq) lat = 4;
        else if (is_lw) lat = 6;
        else lat = 5;
        if (legal) begin
            if (is_j) exp_pc = {m_pc[31:28], i_ins[25:0], 2'b00};
            else if (is_beq && i_z) exp_pc = i_pcp4 + imm * 4;
            else exp_pc = i_pcp4;
            exp_ret  = 16'(m_ret + 16'd1);
            exp_halt = (exp_ret == 16'd43);
        end else begin
            exp_pc = m_pc; exp_ret = m_ret; exp_halt = 1'b1;
        end

        cyc = 0; n_rw = 0; n_mr = 0; n_mw = 0; m2r_rw = 1'b0;
        while (cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
            if (reg_write) begin n_rw++; m2r_rw = mem2reg; end
            if (mem_read) n_mr++;
            if (mem_write) n_mw++;
            if (retired !== m_ret || halted) break;
        end

        chk("latency", cyc, lat);
        chk("pc", pc, exp_pc);
        chk("retired", retired, exp_ret);
        chk("halted", halted, exp_halt);
        chk("busy", busy, !exp_halt);
        chk("illegal", illegal, !legal);
        chk("reg_write_cycles", n_rw, writes ? 1 : 0);
        chk("mem_read_cycles", n_mr, is_lw ? 1 : 0);
        chk("mem_write_cycles", n_mw, is_sw ? 1 : 0);
        if (legal) chk("alu_op", alu_op, exp_op);
        if (writes) begin
            chk("reg_dst", reg_dst, is_r);
            chk("mem2reg_at_wb", m2r_rw, is_lw);
        end
        if (legal && !is_j) chk("alu_src", alu_src, !(is_r || is_beq));
        m_pc = exp_pc; m_ret = exp_ret; m_halt = exp_halt;
    endtask

    function automatic logic [31:0] gen_insn(input bit allow_ill);
        logic [31:0] w;
        logic [5:0]  f;
        logic [5:0]  fns [5];
        int          sel;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        w = $urandom;
        sel = allow_ill ? $urandom_range(0, 31) : $urandom_range(0, 29);
        if (sel < 8) begin
            w[31:26] = 6'h00; w[5:0] = fns[$urandom_range(0, 4)];
        end else if (sel < 12) w[31:26] = 6'h23;
        else if (sel < 16) w[31:26] = 6'h2b;
        else if (sel < 20) w[31:26] = 6'h08;
        else if (sel < 25) w[31:26] = 6'h04;
        else if (sel < 30) w[31:26] = 6'h02;
        else if (sel == 30) begin
            f = 6'($urandom);
            while (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) f = 6'($urandom);
            w[31:26] = 6'h00; w[5:0] = f;
        end else begin
            f = 6'($urandom);
            while (f inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2b}) f = 6'($urandom);
            w[31:26] = f;
        end
        return w;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; ins = '0; pcp4 = '0; imm = '0; jtarget = '0; zero = 1'b0;
        m_pc = 32'd128; m_ret = 16'd0; m_halt = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'd128);
        chk("rst_retired", retired, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_enables", {reg_write, mem_read, mem_write}, 0);
        chk("rst_alu_src", alu_src, 1);
        chk("rst_alu_op", alu_op, 3'b010);
        chk("rst_reg_dst_mem2reg", {reg_dst, mem2reg}, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_pc", pc, 32'd128);

        do_start();
        run_insn(32'h00221820, 32'd132, 1'b0);
        run_insn(32'h8c220004, 32'd136, 1'b0);
        run_insn(32'h10220003, 32'd140, 1'b1);
        chk("beq_taken_pc", pc, 32'd152);
        run_insn(32'h10220003, 32'd140, 1'b0);
        chk("beq_not_taken_pc", pc, 32'd140);

        do_reset();
        do_start();
        run_insn(32'h0800003c, 32'd132, 1'b0);
        chk("j_pc", pc, 32'h000000f0);

        do_reset();
        do_start();
        for (int i = 0; i < 3; i++) run_insn(32'h20210001, m_pc + 32'd4, 1'b0);
        chk("m3_halted", m3_halted, 1);
        chk("m3_busy", m3_busy, 0);
        chk("m3_retired", m3_retired, 3);
        chk("m3_pc", m3_pc, 32'd140);
        chk("m3_illegal", m3_illegal, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("m3_restart_pc", m3_pc, 32'd128);
        chk("m3_restart_retired", m3_retired, 0);
        chk("m3_restart_busy", m3_busy, 1);
        chk("m3_restart_halted", m3_halted, 0);
        chk("busy_start_ignored_retired", retired, 3);
        chk("busy_start_ignored_busy", busy, 1);
        do_reset();

        do_start();
        run_insn(32'hfc000000, 32'd132, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("illegal_sticky", illegal, 1);
        chk("illegal_halted", halted, 1);
        chk("illegal_enables", {reg_write, mem_read, mem_write}, 0);

        do_start();
        run_insn(32'h00221820, 32'd132, 1'b0);
        ins = 32'hac220004; imm = 32'd4; pcp4 = 32'd136;
        repeat (3) @(posedge clk);
        #1;
        chk("sw_mem_write_high", mem_write, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_mem_write", mem_write, 0);
        chk("async_rst_pc", pc, 32'd128);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_retired", retired, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc = 32'd128; m_ret = 16'd0; m_halt = 1'b0;

        do_start();
        for (int i = 0; i < 50; i++) begin
            if (m_halt) do_start();
            run_insn(gen_insn(1'b0), m_pc + 32'd4, 1'($urandom));
        end
        for (int i = 0; i < 60; i++) begin
            if (m_halt) do_start();
            run_insn(gen_insn(1'b1), m_pc + 32'd4, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_ctrl_seq.md
Name: mips_ctrl_seq

Overview:
- Multi-cycle control sequencer for the yIF/yID/yEX/yDM/yWB datapath.
- Sits on the driving end of the datapath control interface.
- Fetches each instruction word, decodes it, and steps the datapath through execute, memory and write-back phases.
- Computes the next PC (sequential, beq, j) and stops after a programmed instruction count or on an illegal opcode.

Parameters:
RESET_PC, 128, PC value loaded on reset and on start.
MAX_INSNS, 43, instructions retired before halting; 0 = run until illegal opcode.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
start  input  1  one-cycle pulse; begins execution from RESET_PC when idle or halted.
ins  input  32  instruction word from yIF at address pc.
pcp4  input  32  pc+4 from yIF.
imm  input  32  sign-extended immediate from yID.
jtarget  input  26  jump target field from yID.
zero  input  1  ALU zero flag from yEX.
pc  output  32  current PC, drives yIF PCin.
reg_dst  output  1  1 = rd destination, 0 = rt destination.
reg_write  output  1  register-file write enable.
alu_src  output  1  1 = immediate operand, 0 = rd2 operand.
mem2reg  output  1  1 = write back memory data.
mem_read  output  1  data-memory read enable.
mem_write  output  1  data-memory write enable.
alu_op  output  3  ALU operation: 000 and, 001 or, 010 add, 110 sub, 111 slt.
busy  output  1  high while executing.
halted  output  1  high after completion or illegal opcode, until start or rst.
illegal  output  1  sticky; set when the halt was caused by an unknown opcode or funct.
retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset (asynchronous): state IDLE, pc=RESET_PC, retired=0, busy=halted=illegal=0.
- Reset values of control outputs: all enables 0, alu_src=1, alu_op=010.
- Control outputs are registered, decoded from an internal ir register, never combinational from ins.
- Enables (reg_write, mem_read, mem_write) are 0 in every state except where stated below.
- IDLE: on start go to FETCH; pc=RESET_PC, retired=0, illegal=0.
- FETCH: ir<=ins; go to DECODE.
- DECODE: set reg_dst, alu_src, mem2reg, alu_op from ir; go to EXEC.
  - Illegal opcode/funct: illegal=1, go to HALT.
- Decode table:
  - R-type (opcode 0): reg_dst=1, alu_src=0. Funct 20 add/010, 22 sub/110, 24 and/000, 25 or/001, 2a slt/111.
  - lw 23: alu_src=1, mem2reg=1, op 010.
  - sw 2b: alu_src=1, op 010.
  - addi 08: alu_src=1, op 010.
  - beq 04: alu_src=0, op 110.
  - j 02: op 010, no enables.
- EXEC: ALU settles, one cycle.
  - lw/sw go to MEM.
  - R-type and addi go to WB.
  - beq and j go to COMMIT.
- MEM: mem_read=1 (lw) or mem_write=1 (sw) for exactly one cycle.
  - lw goes to WB; sw goes to COMMIT.
- WB: reg_write=1 for exactly one cycle; go to COMMIT.
- COMMIT: update pc, increment retired.
  - pc update: beq with zero=1 gives pcp4+(imm<<2); j gives {pc[31:28], jtarget, 2'b00}; otherwise pcp4. All arithmetic is 32-bit modulo.
  - zero is sampled in COMMIT.
  - If MAX_INSNS!=0 and the incremented retired equals MAX_INSNS, go to HALT; else go to FETCH.
- HALT: halted=1, busy=0; start restarts as from IDLE.
- busy=1 in FETCH through COMMIT.
- Latency per instruction: j/beq 4 cycles; R-type/addi/sw 5; lw 6.
- start while busy: ignored.
- retired wraps modulo 2^CNT_W.
- rst mid-instruction: immediate return to reset values. No partial write may remain asserted.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW;
  - funct constants;
  - ALU op encodings;
  - state enumeration.
- Sub-module mips_ctrl_decode: combinational ir-to-control decode plus illegal flag. The sequencer registers its outputs.

Test Plan:
- add $3,$1,$2 (00221820) at pc=128 after start → reg_dst=1, alu_op=010, one reg_write pulse in WB, pc=132 after 5 cycles, retired=1.
- lw (8c220004) → mem_read high exactly one cycle, then reg_write with mem2reg=1; instruction takes 6 cycles.
- beq with zero=1, imm=3, pcp4=140 → pc=152; repeat with zero=0 → pc=140; reg_write and mem_write never asserted.
- j with jtarget=0x000003c, pc=0x00000080 → pc=0x000000f0.
- MAX_INSNS=3, three addi instructions → halted=1, busy=0, retired=3; a following start resets pc to 128 and retired to 0.
- Opcode 3f in DECODE → illegal=1, halted=1, no enables ever asserted. Separately, assert rst while in MEM of an sw → mem_write drops asynchronously and pc=128.
